// File: rtl/obj_dma_ctrl.sv
// Sprite attribute DMA sequencer: copies LEN bytes from work RAM into object RAM under Z80 bus grant.
// Optional OBJ_DMA_WAIT_VBLK_EN holds each armed transfer until vertical blank; otherwise vblk is ignored.
module obj_dma_ctrl #(
    parameter logic [15:0] SRC_BASE = 16'h6900,
    parameter logic [9:0]  DST_BASE = 10'h000,
    parameter int          LEN      = 384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_ce,
    input  logic        dma_trig,
    input  logic        vblk,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic [15:0] src_addr,
    output logic        src_rdn,
    input  logic [7:0]  src_data,
    output logic [9:0]  dst_addr,
    output logic        dst_wrn,
    output logic [7:0]  dst_data,
    output logic        dma_busy,
    output logic        dma_done
);

    // state   | meaning
    // IDLE    | no transfer; waits for a pending trigger
    // WAIT_VB | armed, waiting for vertical blank
    // REQ     | BUSRQ asserted, waiting for BUSAK
    // RD      | read strobe on work RAM for byte `count`
    // WR      | write strobe on obj RAM for the captured byte
    // REL     | bus released, done pulse
    typedef enum logic [2:0] {IDLE, WAIT_VB, REQ, RD, WR, REL} state_t;

    localparam logic [10:0] LEN_C = 11'(LEN);

    state_t      state, state_nxt;
    logic [10:0] count, count_nxt;
    logic        pending, pending_nxt;
    logic        busrq_nxt, src_rdn_nxt, dst_wrn_nxt, done_nxt;
    logic [15:0] src_addr_nxt;
    logic [9:0]  dst_addr_nxt;
    logic [7:0]  dst_data_nxt;

`ifndef OBJ_DMA_WAIT_VBLK_EN
    logic unused_vblk;
    assign unused_vblk = vblk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            pending  <= 1'b0;
            busrq_n  <= 1'b1;
            src_rdn  <= 1'b1;
            dst_wrn  <= 1'b1;
            src_addr <= SRC_BASE;
            dst_addr <= DST_BASE;
            dst_data <= '0;
            dma_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            pending  <= pending_nxt;
            busrq_n  <= busrq_nxt;
            src_rdn  <= src_rdn_nxt;
            dst_wrn  <= dst_wrn_nxt;
            src_addr <= src_addr_nxt;
            dst_addr <= dst_addr_nxt;
            dst_data <= dst_data_nxt;
            dma_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        pending_nxt  = pending | dma_trig;
        busrq_nxt    = busrq_n;
        src_rdn_nxt  = src_rdn;
        dst_wrn_nxt  = dst_wrn;
        src_addr_nxt = src_addr;
        dst_addr_nxt = dst_addr;
        dst_data_nxt = dst_data;
        done_nxt     = 1'b0;

        if (step_ce) begin
            case (state)
                IDLE: begin
                    if (pending) begin
`ifdef OBJ_DMA_WAIT_VBLK_EN
                        state_nxt = WAIT_VB;
`else
                        state_nxt   = REQ;
                        busrq_nxt   = 1'b0;
                        count_nxt   = '0;
                        pending_nxt = dma_trig;
`endif
                    end
                end
`ifdef OBJ_DMA_WAIT_VBLK_EN
                WAIT_VB: begin
                    if (vblk) begin
                        state_nxt   = REQ;
                        busrq_nxt   = 1'b0;
                        count_nxt   = '0;
                        pending_nxt = dma_trig;
                    end
                end
`endif
                REQ: begin
                    if (!busak_n) begin
                        state_nxt    = RD;
                        src_rdn_nxt  = 1'b0;
                        src_addr_nxt = SRC_BASE + {5'b0, count};
                    end
                end
                RD: begin
                    // A read interrupted by loss of BUSAK is reissued, so data is only taken from a full strobe.
                    if (busak_n) begin
                        src_rdn_nxt = 1'b1;
                    end else if (src_rdn) begin
                        src_rdn_nxt = 1'b0;
                    end else begin
                        state_nxt    = WR;
                        src_rdn_nxt  = 1'b1;
                        dst_data_nxt = src_data;
                        dst_wrn_nxt  = 1'b0;
                        dst_addr_nxt = DST_BASE + count[9:0];
                        count_nxt    = count + 11'd1;
                    end
                end
                WR: begin
                    dst_wrn_nxt = 1'b1;
                    if (!busak_n) begin
                        if (count == LEN_C) begin
                            state_nxt = REL;
                            busrq_nxt = 1'b1;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt    = RD;
                            src_rdn_nxt  = 1'b0;
                            src_addr_nxt = SRC_BASE + {5'b0, count};
                        end
                    end
                end
                REL:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign dma_busy = (state != IDLE);

endmodule

// File: tb/tb_obj_dma_ctrl.sv
// Directed bench for obj_dma_ctrl: one default instance (LEN=384) and one wrapping instance (DST_BASE=3F0h, LEN=32).
module tb_obj_dma_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, step_ce = 1'b1, vblk = 1'b1;
    logic trig_a = 1'b0, trig_b = 1'b0;
    logic busrq_n_a, busak_n_a, src_rdn_a, dst_wrn_a, busy_a, done_a;
    logic busrq_n_b, busak_n_b, src_rdn_b, dst_wrn_b, busy_b, done_b;
    logic [15:0] src_addr_a, src_addr_b;
    logic [7:0]  src_data_a, src_data_b, dst_data_a, dst_data_b;
    logic [9:0]  dst_addr_a, dst_addr_b;
    logic ack_n_a = 1'b1, ack_n_b = 1'b1, hold_a = 1'b0;

    int vec = 0, err = 0, cyc = 0;
    int wr_cnt_a[1024], wr_cnt_b[1024];
    logic [7:0] wr_dat_a[1024], wr_dat_b[1024];
    int wr_tot_a = 0, wr_tot_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int done_cyc_a = 0, done_cyc_b = 0, ack_cyc_a = 0, ack_cyc_b = 0, rq_a = 0, rq_b = 0;

    assign busak_n_a = ack_n_a | hold_a;
    assign busak_n_b = ack_n_b;

    // Work RAM image: byte at 6900h+i holds i^5Ah.
    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h6900;
        return off[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] b;
        b = i[7:0];
        return b ^ 8'h5A;
    endfunction

    assign src_data_a = ram_byte(src_addr_a);
    assign src_data_b = ram_byte(src_addr_b);

    obj_dma_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .step_ce(step_ce), .dma_trig(trig_a), .vblk(vblk),
        .busrq_n(busrq_n_a), .busak_n(busak_n_a), .src_addr(src_addr_a), .src_rdn(src_rdn_a),
        .src_data(src_data_a), .dst_addr(dst_addr_a), .dst_wrn(dst_wrn_a), .dst_data(dst_data_a),
        .dma_busy(busy_a), .dma_done(done_a)
    );

    obj_dma_ctrl #(.SRC_BASE(16'h6900), .DST_BASE(10'h3F0), .LEN(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .step_ce(step_ce), .dma_trig(trig_b), .vblk(vblk),
        .busrq_n(busrq_n_b), .busak_n(busak_n_b), .src_addr(src_addr_b), .src_rdn(src_rdn_b),
        .src_data(src_data_b), .dst_addr(dst_addr_b), .dst_wrn(dst_wrn_b), .dst_data(dst_data_b),
        .dma_busy(busy_b), .dma_done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write logger, done counter and BUSAK responder (ack two steps after BUSRQ).
    always @(negedge clk) begin
        if (!rst_n) begin
            rq_a = 0; ack_n_a = 1'b1; rq_b = 0; ack_n_b = 1'b1;
        end else begin
            if (step_ce && !dst_wrn_a) begin
                wr_cnt_a[dst_addr_a]++; wr_dat_a[dst_addr_a] = dst_data_a; wr_tot_a++;
            end
            if (step_ce && !dst_wrn_b) begin
                wr_cnt_b[dst_addr_b]++; wr_dat_b[dst_addr_b] = dst_data_b; wr_tot_b++;
            end
            if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
            if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
            rq_a = busrq_n_a ? 0 : rq_a + 1;
            rq_b = busrq_n_b ? 0 : rq_b + 1;
            if (ack_n_a && rq_a >= 2) ack_cyc_a = cyc;
            if (ack_n_b && rq_b >= 2) ack_cyc_b = cyc;
            ack_n_a = !(rq_a >= 2);
            ack_n_b = !(rq_b >= 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 1024; i++) begin
            wr_cnt_a[i] = 0; wr_cnt_b[i] = 0; wr_dat_a[i] = '0; wr_dat_b[i] = '0;
        end
        wr_tot_a = 0; wr_tot_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    endtask

    task automatic pulse_a();
        trig_a = 1'b1; tick(); trig_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input string tag);
        for (int i = 0; i < 5000 && done_cnt_a < target; i++) tick();
        vec++;
        if (done_cnt_a < target) begin
            err++; $display("FAIL %s done timeout got %0d want %0d", tag, done_cnt_a, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        vec++; if (busrq_n_a !== 1'b1) begin err++; $display("FAIL reset busrq_n got %b want 1", busrq_n_a); end
        vec++; if (src_rdn_a !== 1'b1) begin err++; $display("FAIL reset src_rdn got %b want 1", src_rdn_a); end
        vec++; if (dst_wrn_a !== 1'b1) begin err++; $display("FAIL reset dst_wrn got %b want 1", dst_wrn_a); end
        vec++; if (src_addr_a !== 16'h6900) begin err++; $display("FAIL reset src_addr got %h want 6900", src_addr_a); end
        vec++; if (dst_addr_a !== 10'h000) begin err++; $display("FAIL reset dst_addr got %h want 000", dst_addr_a); end
        vec++; if (dst_data_a !== 8'h00) begin err++; $display("FAIL reset dst_data got %h want 00", dst_data_a); end
        vec++; if (busy_a !== 1'b0) begin err++; $display("FAIL reset dma_busy got %b want 0", busy_a); end
        vec++; if (done_a !== 1'b0) begin err++; $display("FAIL reset dma_done got %b want 0", done_a); end
        vec++; if (dst_addr_b !== 10'h3F0) begin err++; $display("FAIL reset dst_addr_b got %h want 3f0", dst_addr_b); end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        clear_logs();
        vblk = 1'b1;
        pulse_a();
        wait_done_a(1, "single");
        tick(); tick(); tick();
        vec++; if (done_cnt_a !== 1) begin err++; $display("FAIL single done_count got %0d want 1", done_cnt_a); end
        vec++; if (done_cyc_a - ack_cyc_a - 1 !== 768) begin err++; $display("FAIL single steps_after_ack got %0d want 768", done_cyc_a - ack_cyc_a - 1); end
        vec++; if (busrq_n_a !== 1'b1) begin err++; $display("FAIL single busrq_n_after got %b want 1", busrq_n_a); end
        vec++; if (busy_a !== 1'b0) begin err++; $display("FAIL single busy_after got %b want 0", busy_a); end
        vec++; if (wr_tot_a !== 384) begin err++; $display("FAIL single write_total got %0d want 384", wr_tot_a); end
        for (int i = 0; i < 384; i++) begin
            vec++;
            if (wr_cnt_a[i] !== 1 || wr_dat_a[i] !== exp_byte(i)) begin
                err++; $display("FAIL single obj[%0d] got cnt %0d data %h want cnt 1 data %h", i, wr_cnt_a[i], wr_dat_a[i], exp_byte(i));
            end
        end
    endtask

    task automatic test_vblk();
        clear_logs();
        vblk = 1'b0;
        pulse_a();
        tick();
`ifdef OBJ_DMA_WAIT_VBLK_EN
        repeat (8) tick();
        vec++; if (busrq_n_a !== 1'b1) begin err++; $display("FAIL vblk_wait busrq_n got %b want 1", busrq_n_a); end
        vec++; if (busy_a !== 1'b1) begin err++; $display("FAIL vblk_wait busy got %b want 1", busy_a); end
        vblk = 1'b1;
        tick();
        vec++; if (busrq_n_a !== 1'b0) begin err++; $display("FAIL vblk_rise busrq_n got %b want 0", busrq_n_a); end
`else
        vec++; if (busrq_n_a !== 1'b0) begin err++; $display("FAIL vblk_ignored busrq_n got %b want 0", busrq_n_a); end
        vec++; if (busy_a !== 1'b1) begin err++; $display("FAIL vblk_ignored busy got %b want 1", busy_a); end
`endif
        wait_done_a(1, "vblk");
        vblk = 1'b1;
        tick(); tick();
        vec++; if (wr_tot_a !== 384) begin err++; $display("FAIL vblk write_total got %0d want 384", wr_tot_a); end
    endtask

    task automatic test_freeze();
        clear_logs();
        pulse_a();
        for (int i = 0; i < 2000 && wr_tot_a < 100; i++) tick();
        hold_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            vec++;
            if ({busrq_n_a, src_rdn_a, dst_wrn_a} !== 3'b011) begin
                err++; $display("FAIL freeze step %0d busrq/rdn/wrn got %b want 011", k, {busrq_n_a, src_rdn_a, dst_wrn_a});
            end
        end
        hold_a = 1'b0;
        wait_done_a(1, "freeze");
        tick(); tick();
        vec++; if (wr_tot_a !== 384) begin err++; $display("FAIL freeze write_total got %0d want 384", wr_tot_a); end
        for (int i = 0; i < 384; i++) begin
            vec++;
            if (wr_cnt_a[i] !== 1 || wr_dat_a[i] !== exp_byte(i)) begin
                err++; $display("FAIL freeze obj[%0d] got cnt %0d data %h want cnt 1 data %h", i, wr_cnt_a[i], wr_dat_a[i], exp_byte(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        pulse_a();
        for (int i = 0; i < 2000 && wr_tot_a < 10; i++) tick();
        pulse_a(); tick(); tick();
        pulse_a(); tick(); tick();
        pulse_a();
        wait_done_a(2, "back_to_back");
        repeat (20) tick();
        vec++; if (done_cnt_a !== 2) begin err++; $display("FAIL b2b done_count got %0d want 2", done_cnt_a); end
        vec++; if (busy_a !== 1'b0) begin err++; $display("FAIL b2b busy_after got %b want 0", busy_a); end
        vec++; if (wr_tot_a !== 768) begin err++; $display("FAIL b2b write_total got %0d want 768", wr_tot_a); end
        for (int i = 0; i < 384; i++) begin
            vec++;
            if (wr_cnt_a[i] !== 2 || wr_dat_a[i] !== exp_byte(i)) begin
                err++; $display("FAIL b2b obj[%0d] got cnt %0d data %h want cnt 2 data %h", i, wr_cnt_a[i], wr_dat_a[i], exp_byte(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        pulse_a();
        for (int i = 0; i < 2000 && wr_tot_a < 50; i++) tick();
        pulse_a();
        rst_n = 1'b0;
        #1;
        vec++; if (busrq_n_a !== 1'b1) begin err++; $display("FAIL rst_mid busrq_n got %b want 1", busrq_n_a); end
        vec++; if (dst_wrn_a !== 1'b1) begin err++; $display("FAIL rst_mid dst_wrn got %b want 1", dst_wrn_a); end
        vec++; if (src_rdn_a !== 1'b1) begin err++; $display("FAIL rst_mid src_rdn got %b want 1", src_rdn_a); end
        vec++; if (busy_a !== 1'b0) begin err++; $display("FAIL rst_mid busy got %b want 0", busy_a); end
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        vec++; if (busy_a !== 1'b0) begin err++; $display("FAIL rst_mid pending_cleared busy got %b want 0", busy_a); end
        clear_logs();
        pulse_a();
        wait_done_a(1, "rst_restart");
        tick(); tick();
        vec++; if (wr_tot_a !== 384) begin err++; $display("FAIL rst_restart write_total got %0d want 384", wr_tot_a); end
        for (int i = 0; i < 384; i++) begin
            vec++;
            if (wr_cnt_a[i] !== 1 || wr_dat_a[i] !== exp_byte(i)) begin
                err++; $display("FAIL rst_restart obj[%0d] got cnt %0d data %h want cnt 1 data %h", i, wr_cnt_a[i], wr_dat_a[i], exp_byte(i));
            end
        end
    endtask

    task automatic test_step_ce();
        clear_logs();
        step_ce = 1'b0;
        pulse_a();
        repeat (4) tick();
        vec++; if (busy_a !== 1'b0) begin err++; $display("FAIL step_ce_hold busy got %b want 0", busy_a); end
        step_ce = 1'b1;
        tick();
        vec++; if (busy_a !== 1'b1) begin err++; $display("FAIL step_ce_armed busy got %b want 1", busy_a); end
        wait_done_a(1, "step_ce");
        tick(); tick();
        vec++; if (done_cnt_a !== 1) begin err++; $display("FAIL step_ce done_count got %0d want 1", done_cnt_a); end
    endtask

    task automatic test_wrap();
        logic [9:0] a;
        clear_logs();
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        for (int i = 0; i < 1000 && done_cnt_b < 1; i++) tick();
        tick(); tick();
        vec++; if (done_cnt_b !== 1) begin err++; $display("FAIL wrap done_count got %0d want 1", done_cnt_b); end
        vec++; if (done_cyc_b - ack_cyc_b - 1 !== 64) begin err++; $display("FAIL wrap steps_after_ack got %0d want 64", done_cyc_b - ack_cyc_b - 1); end
        vec++; if (wr_tot_b !== 32) begin err++; $display("FAIL wrap write_total got %0d want 32", wr_tot_b); end
        for (int k = 0; k < 32; k++) begin
            a = 10'h3F0 + 10'(k);
            vec++;
            if (wr_cnt_b[a] !== 1 || wr_dat_b[a] !== exp_byte(k)) begin
                err++; $display("FAIL wrap obj[%h] got cnt %0d data %h want cnt 1 data %h", a, wr_cnt_b[a], wr_dat_b[a], exp_byte(k));
            end
        end
        vec++; if (wr_cnt_b[16] !== 0 || wr_cnt_b[1007] !== 0) begin
            err++; $display("FAIL wrap outside_writes got %0d/%0d want 0/0", wr_cnt_b[16], wr_cnt_b[1007]);
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_single();
        test_vblk();
        test_freeze();
        test_back_to_back();
        test_reset_mid();
        test_step_ce();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached after %0d vectors", vec);
        $fatal(1, "watchdog");
    end
endmodule
